// File: rtl/accum_search_ctrl_if.sv
// rtl/accum_search_ctrl_if.sv - request/valid read port between the search controller and the array memory
interface accum_search_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/accum_search_ctrl.sv
// rtl/accum_search_ctrl.sv - scans the array, sums elements matching a key rule until a target is reached
// Optional MATCH_COUNT_EN adds o_match_count, the number of accumulated elements in the current scan.
module accum_search_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int SUM_WIDTH = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [WIDTH-1:0]     i_key,
  input  logic [SUM_WIDTH-1:0] i_target,
  accum_search_ctrl_if.master  mem,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_success,
  output logic [SUM_WIDTH-1:0] o_sum,
  output logic [AW-1:0]        o_index,
  output logic [2:0]           o_state
`ifdef MATCH_COUNT_EN
  ,
  output logic [AW:0]          o_match_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [1:0]           r_mode;
  logic [WIDTH-1:0]     r_key;
  logic [SUM_WIDTH-1:0] r_target;
  logic [WIDTH-1:0]     r_data;
  logic [AW-1:0]        r_addr;
  logic [SUM_WIDTH-1:0] r_sum;
  logic [AW-1:0]        r_index;
  logic                 r_success;
`ifdef MATCH_COUNT_EN
  logic [AW:0]          r_match_count;
`endif

  logic                 w_match;
  logic                 w_last;
  logic                 w_reached;
  logic                 w_accept;
  logic [SUM_WIDTH:0]   w_sum_ext;
  logic [SUM_WIDTH-1:0] w_sum_sat;

  always_comb begin
    w_match = 1'b0;
    case (r_mode)
      2'b00:   w_match = (r_data == r_key);
      2'b01:   w_match = (r_data > r_key);
      2'b10:   w_match = (r_data < r_key);
      default: w_match = 1'b1;
    endcase
  end

  // Carry out of the widened add means overflow; clamp instead of wrapping.
  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_WIDTH + 1 - WIDTH){1'b0}}, r_data};
  assign w_sum_sat = w_sum_ext[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : w_sum_ext[SUM_WIDTH-1:0];
  assign w_reached = (w_sum_sat >= r_target);
  assign w_last    = (r_addr == AW'(DEPTH - 1));
  assign w_accept  = i_start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_next_state = (i_target == '0) ? S_DONE : S_READ;
      end
      S_READ:   if (mem.rd_valid) w_next_state = S_CHECK;
      S_CHECK: begin
        if (w_match)     w_next_state = S_UPDATE;
        else if (w_last) w_next_state = S_DONE;
        else             w_next_state = S_READ;
      end
      S_UPDATE: w_next_state = (w_reached || w_last) ? S_DONE : S_READ;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem.rd_req  = (r_state == S_READ);
    mem.rd_addr = r_addr;
    o_busy      = (r_state == S_READ) || (r_state == S_CHECK) || (r_state == S_UPDATE);
    o_done      = (r_state == S_DONE);
    o_success   = r_success;
    o_sum       = r_sum;
    o_index     = r_index;
    o_state     = r_state;
`ifdef MATCH_COUNT_EN
    o_match_count = r_match_count;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode    <= '0;
      r_key     <= '0;
      r_target  <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_sum     <= '0;
      r_index   <= '0;
      r_success <= 1'b0;
`ifdef MATCH_COUNT_EN
      r_match_count <= '0;
`endif
    end else if (w_accept) begin
      r_mode    <= i_mode;
      r_key     <= i_key;
      r_target  <= i_target;
      r_addr    <= '0;
      r_sum     <= '0;
      r_index   <= '0;
      r_success <= (i_target == '0);
`ifdef MATCH_COUNT_EN
      r_match_count <= '0;
`endif
    end else begin
      case (r_state)
        S_READ:  if (mem.rd_valid) r_data <= mem.rd_data;
        S_CHECK: if (!w_match && !w_last) r_addr <= r_addr + 1'b1;
        S_UPDATE: begin
          r_sum   <= w_sum_sat;
          r_index <= r_addr;
`ifdef MATCH_COUNT_EN
          r_match_count <= r_match_count + 1'b1;
`endif
          if (w_reached)    r_success <= 1'b1;
          else if (!w_last) r_addr    <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_search_ctrl.sv
// tb/tb_accum_search_ctrl.sv - scoreboard bench for accum_search_ctrl with a zero/variable-wait memory model
module tb_accum_search_ctrl;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int SUM_WIDTH = 8;
  localparam int AW        = $clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_start;
  logic [1:0]           i_mode;
  logic [WIDTH-1:0]     i_key;
  logic [SUM_WIDTH-1:0] i_target;
  logic                 o_busy, o_done, o_success;
  logic [SUM_WIDTH-1:0] o_sum;
  logic [AW-1:0]        o_index;
  logic [2:0]           o_state;
`ifdef MATCH_COUNT_EN
  logic [AW:0]          o_match_count;
`endif

  accum_search_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) mem_if ();

  always #5 clk = ~clk;

  accum_search_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SUM_WIDTH(SUM_WIDTH)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_key(i_key),
    .i_target(i_target), .mem(mem_if.master), .o_busy(o_busy), .o_done(o_done),
    .o_success(o_success), .o_sum(o_sum), .o_index(o_index), .o_state(o_state)
`ifdef MATCH_COUNT_EN
    , .o_match_count(o_match_count)
`endif
  );

  // Memory model: valid in the same cycle as the request, except delay_cycles extra cycles at delay_addr.
  logic [WIDTH-1:0] mem [DEPTH];
  int delay_addr   = -1;
  int delay_cycles = 0;
  int req_age      = 0;
  always_ff @(posedge clk) begin
    if (mem_if.rd_req && !mem_if.rd_valid) req_age <= req_age + 1;
    else                                   req_age <= 0;
  end
  assign mem_if.rd_valid = mem_if.rd_req && (int'(mem_if.rd_addr) != delay_addr || req_age >= delay_cycles);
  assign mem_if.rd_data  = mem[mem_if.rd_addr];

  int n_checks = 0;
  int n_pass   = 0;
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic                 success;
    logic [SUM_WIDTH-1:0] sum;
    logic [AW-1:0]        index;
    int                   nreads;
    int                   maxaddr;
  } exp_t;
  exp_t sb[$];

  // Monitor: counts reads per scan and checks the result against the queue when done appears.
  exp_t e;
  int   m_reads = 0;
  int   m_max   = 0;
  bit   armed   = 0;
  always @(negedge clk) begin
    if (reset) begin
      armed = 0;
    end else begin
      if (armed && o_done) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("success", o_success, e.success);
          check("sum", o_sum, e.sum);
          check("index", o_index, e.index);
          check("reads", m_reads, e.nreads);
          check("max_addr", m_max, e.maxaddr);
        end
        armed = 0;
      end
      if (mem_if.rd_req && mem_if.rd_valid) begin
        m_reads++;
        if (int'(mem_if.rd_addr) > m_max) m_max = int'(mem_if.rd_addr);
      end
      if (i_start && (o_state == 3'd0 || o_state == 3'd4)) begin
        armed   = 1;
        m_reads = 0;
        m_max   = 0;
      end
    end
  end

  task automatic start_scan(input logic [1:0] mode, input logic [WIDTH-1:0] key,
                            input logic [SUM_WIDTH-1:0] target, input bit push,
                            input logic succ, input logic [SUM_WIDTH-1:0] sum,
                            input logic [AW-1:0] idx, input int nreads, input int maxaddr);
    exp_t x;
    x.success = succ; x.sum = sum; x.index = idx; x.nreads = nreads; x.maxaddr = maxaddr;
    if (push) sb.push_back(x);
    @(posedge clk); #1;
    i_mode = mode; i_key = key; i_target = target; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    // Scrambled inputs mid-scan must be ignored.
    i_mode = mode ^ 2'b01; i_key = ~key; i_target = ~target;
    check("post_start_state", o_state, (target == '0) ? 4 : 1);
    check("post_start_sum", o_sum, 0);
    check("post_start_addr", mem_if.rd_addr, 0);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300 && !o_done; c++) @(negedge clk);
    if (!o_done) check("done_timeout", 0, 1);
  endtask

  task automatic load_t2();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[0] = 8'd5; mem[1] = 8'd3; mem[2] = 8'd5; mem[3] = 8'd5;
  endtask

  task automatic fill(input logic [WIDTH-1:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_rd_req"}, mem_if.rd_req, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_success"}, o_success, 0);
    check({tag, "_sum"}, o_sum, 0);
    check({tag, "_index"}, o_index, 0);
    check({tag, "_rd_addr"}, mem_if.rd_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset = 1'b1; i_start = 1'b0; i_mode = '0; i_key = '0; i_target = '0;
    fill('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    load_t2();
    start_scan(2'b00, 8'd5, 8'd10, 1, 1'b1, 8'd10, 4'd2, 3, 2);
    wait_done();

    fill(8'd7);
    start_scan(2'b01, 8'd200, 8'd1, 1, 1'b0, 8'd0, 4'd0, 16, 15);
    wait_done();
    @(negedge clk);
    check("t3_rd_req_after_last", mem_if.rd_req, 0);

    load_t2();
    delay_addr = 1; delay_cycles = 3;
    start_scan(2'b00, 8'd5, 8'd10, 1, 1'b1, 8'd10, 4'd2, 3, 2);
    for (int c = 0; c < 50 && !(o_state == 3'd1 && mem_if.rd_addr == 4'd1); c++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("t4_state_read", o_state, 1);
      check("t4_rd_req", mem_if.rd_req, 1);
      check("t4_rd_addr", mem_if.rd_addr, 1);
      @(negedge clk);
    end
    wait_done();
    delay_addr = -1; delay_cycles = 0;

    fill(8'hFF);
    start_scan(2'b11, 8'd0, 8'hFF, 1, 1'b1, 8'hFF, 4'd0, 1, 0);
    wait_done();
    start_scan(2'b11, 8'd0, 8'h00, 1, 1'b1, 8'h00, 4'd0, 0, 0);
    wait_done();

    fill('0);
    mem[0] = 8'h80; mem[1] = 8'h90;
    start_scan(2'b11, 8'd0, 8'hFF, 1, 1'b1, 8'hFF, 4'd1, 2, 1);
    wait_done();

    load_t2();
    start_scan(2'b10, 8'd4, 8'd100, 1, 1'b0, 8'd3, 4'd15, 16, 15);
    wait_done();

    fill(8'd3);
    start_scan(2'b11, 8'd0, 8'hFF, 0, 1'b0, 8'd0, 4'd0, 0, 0);
    for (int c = 0; c < 50 && !(o_state == 3'd3 && o_sum != '0); c++) @(negedge clk);
    check("t6_in_update", o_state, 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("t6_reset");
    reset = 1'b0;
    load_t2();
    start_scan(2'b00, 8'd5, 8'd10, 1, 1'b1, 8'd10, 4'd2, 3, 2);
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/accum_search_ctrl.md
Name: accum_search_ctrl

Overview:
Parametrised controller plus datapath that scans a DEPTH-entry memory of WIDTH-bit words through a request/valid read port. It selects elements with a mode-programmable comparison against a key and accumulates the selected elements into a sum. It reports success when the sum reaches a target, or failure when the scan is exhausted. The block is the next-generation search/sum sequencer and drives the array memory directly; no external wr_sum/wr_index strobes are needed.

Parameters:
WIDTH, 8, element and key width in bits
DEPTH, 16, number of memory entries scanned (>=2)
SUM_WIDTH, 16, accumulator and target width (must be >= WIDTH)
AW (localparam), $clog2(DEPTH), address/index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a scan; sampled only in IDLE and DONE
mode  in  2  match rule: 00 equal, 01 greater-than, 10 less-than, 11 any (all match); unsigned compares
key  in  WIDTH  comparison key
target  in  SUM_WIDTH  sum threshold
rd_req  out  1  read request, asserted only in READ
rd_addr  out  AW  read address
rd_valid  in  1  read data valid; ignored outside READ
rd_data  in  WIDTH  read data
busy  out  1  high in READ/CHECK/UPDATE
done  out  1  high while in DONE
success  out  1  valid while done: 1 = target reached
sum  out  SUM_WIDTH  accumulated sum
index  out  AW  address of last matched element
state  out  3  current FSM state: IDLE=0, READ=1, CHECK=2, UPDATE=3, DONE=4

Behaviour:
- Reset (clk edge with reset=1): state IDLE. rd_req, busy, done, success = 0. sum, index, rd_addr = 0. Reset wins over every other input, including mid-scan and during a pending read.
- IDLE/DONE + start: latch mode, key, target; clear sum, index, address, success.
  - Next state READ; if latched target==0, next state DONE with success=1 and no reads issued.
- DONE without start: hold all outputs.
- READ: rd_req=1, rd_addr=address counter.
  - Remain in READ until rd_valid=1, holding rd_addr stable.
  - On rd_valid, capture rd_data into a data register and go to CHECK. rd_valid may arrive in the same cycle rd_req first rises.
- CHECK: evaluate match on the captured data.
  - match -> UPDATE.
  - no match and address==DEPTH-1 -> DONE, success=0.
  - no match otherwise -> address+1, READ.
- UPDATE: sum <= sum + data, saturating at 2^SUM_WIDTH-1 (no wrap); index <= address.
  - new sum >= target -> DONE, success=1.
  - else address==DEPTH-1 -> DONE, success=0.
  - else address+1, READ.
- Address never wraps; the last element is always checked before failure.
- Latency per element with zero-wait memory: non-match 2 cycles, match 3 cycles.
- mode/key/target changes during a scan have no effect.

Optional Feature:
Macro MATCH_COUNT_EN.
- Defined: adds output match_count [AW:0]. It clears on start, increments in each UPDATE, holds in DONE, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Assert reset for 2 cycles -> state=0; rd_req, busy, done, success = 0; sum=0, index=0, rd_addr=0.
2. mode=00, key=5, target=10, mem=[5,3,5,5,0...], zero-wait -> done with success=1, sum=10, index=2; 3 reads issued; rd_addr never exceeds 2.
3. mode=01, key=200, target=1, all mem=7 -> 16 reads at addr 0..15, then done with success=0, sum=0; rd_req deasserts after addr 15.
4. rd_valid delayed 3 cycles on addr 1 -> state stays READ, rd_req=1 and rd_addr=1 stable for 4 cycles; the final result is unchanged versus zero-wait.
5. WIDTH=8, SUM_WIDTH=8, mode=11, all mem=0xFF, target=0xFF -> success after the first element, sum=0xFF. Same setup with target=0 -> done 1 cycle after start, rd_req never asserted.
6. Assert reset while in UPDATE mid-scan -> state IDLE and all outputs 0 next cycle. A new start then scans from addr 0 with sum cleared.
